// File: rtl/pwm_ctrl_apb.sv
// pwm_ctrl_apb
// ------------
// APB3-style 16-bit slave holding the PWM configuration registers, together
// with a 16-bit free-running period counter that drives one PWM output.
// Everything runs in the pclk domain. Reset is synchronous and active-high.
//
// Register map (offset = paddr[3:0], upper address bits ignored so the map aliases):
//   0x0 DUTY   RW  high-time in counter ticks (double-buffered into duty_act)
//   0x4 PERIOD RW  counter terminal value; the period is PERIOD+1 cycles
//   0x8 CTRL   RW  bit0 EN (counter run), bit1 POL (output inversion)
//   0xC CNT    RO  current counter value
//
// Ports:
//   pclk, preset          clock and synchronous active-high reset
//   paddr, pwdata, pwrite APB address, write data and direction
//   psel, penable, pstrb  APB select, access phase and byte-lane strobes
//   prdata, pready        combinational read data; pready is always 1
//   pslverr               error on misaligned access or write to CNT
//   pwm_o                 registered PWM output
module pwm_ctrl_apb #(
  parameter logic [15:0] DUTY_RST   = 16'h0000,
  parameter logic [15:0] PERIOD_RST = 16'hFFFF,
  parameter logic        EN_RST     = 1'b1
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic [31:0] paddr,
  input  logic [15:0] pwdata,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  input  logic [1:0]  pstrb,
  output logic [15:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        pwm_o
);

  logic [15:0] duty;
  logic [15:0] period;
  logic        ctrl_en;
  logic        ctrl_pol;
  logic [15:0] cnt;
  logic [15:0] duty_act;

  logic [3:0]  offset;
  logic        access;
  logic        bad_access;
  logic        wr_en;
  logic [15:0] wmask;
  logic        unused_addr_bits;

  assign offset = paddr[3:0];
  assign unused_addr_bits = ^paddr[31:4];

  assign access = psel & penable;

  // Misaligned offsets and any write to the read-only counter are errors;
  // an erroring write is suppressed so it cannot alias onto a real register.
  assign bad_access = (paddr[1:0] != 2'b00) | (pwrite & (offset == 4'hC));
  assign pslverr    = access & bad_access;
  assign wr_en      = access & pwrite & ~bad_access;
  assign pready     = 1'b1;

  assign wmask = {{8{pstrb[1]}}, {8{pstrb[0]}}};

  function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic [15:0] mask);
    merge_bytes = (old_val & ~mask) | (new_val & mask);
  endfunction

  // Register writes; only CTRL bits 1:0 exist, so only the low byte lane matters there.
  always_ff @(posedge pclk) begin
    if (preset) begin
      duty     <= DUTY_RST;
      period   <= PERIOD_RST;
      ctrl_en  <= EN_RST;
      ctrl_pol <= 1'b0;
    end else if (wr_en) begin
      case (offset[3:2])
        2'd0: duty   <= merge_bytes(duty, pwdata, wmask);
        2'd1: period <= merge_bytes(period, pwdata, wmask);
        2'd2: begin
          if (pstrb[0]) begin
            ctrl_en  <= pwdata[0];
            ctrl_pol <= pwdata[1];
          end
        end
        default: ;
      endcase
    end
  end

  // Period counter and double buffer. duty_act only reloads at the wrap (or
  // continuously while stopped), so a DUTY write never disturbs the period in
  // progress. The equality compare means a PERIOD written below cnt lets the
  // counter run through the 16-bit overflow before it meets the new value.
  always_ff @(posedge pclk) begin
    if (preset) begin
      cnt      <= 16'h0000;
      duty_act <= DUTY_RST;
      pwm_o    <= 1'b0;
    end else if (!ctrl_en) begin
      cnt      <= 16'h0000;
      duty_act <= duty;
      pwm_o    <= ctrl_pol;
    end else begin
      if (cnt == period) begin
        cnt      <= 16'h0000;
        duty_act <= duty;
      end else begin
        cnt <= cnt + 16'd1;
      end
      pwm_o <= (cnt < duty_act) ^ ctrl_pol;
    end
  end

  // Combinational read mux; misaligned offsets read back as zero.
  always_comb begin
    prdata = 16'h0000;
    if (psel && !pwrite && (paddr[1:0] == 2'b00)) begin
      case (offset[3:2])
        2'd0:    prdata = duty;
        2'd1:    prdata = period;
        2'd2:    prdata = {14'h0000, ctrl_pol, ctrl_en};
        default: prdata = cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ctrl_apb.sv
// tb_pwm_ctrl_apb
// ---------------
// Directed testbench for pwm_ctrl_apb. Drives APB transfers on the falling
// edge, samples outputs on the falling edge, and compares against
// hand-computed constants. PWM waveforms are captured as 20-cycle bit
// vectors (first sample in the MSB) starting at the first rising edge
// after a CTRL write that enables the counter.
module tb_pwm_ctrl_apb;

  logic        pclk;
  logic        preset;
  logic [31:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [1:0]  pstrb;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        pwm_o;

  int checkCount;
  int passCount;

  pwm_ctrl_apb dut (
    .pclk    (pclk),
    .preset  (preset),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pstrb   (pstrb),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .pwm_o   (pwm_o)
  );

  // 10 ns clock
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Two-phase APB write; returns on the falling edge after the commit edge.
  task automatic apbWrite(input logic [31:0] addr, input logic [15:0] data,
                          input logic [1:0] strb, output logic err);
    @(negedge pclk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(negedge pclk);
    penable = 1'b1;
    #1 err = pslverr;
    @(negedge pclk);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // Two-phase APB read, data sampled during the access phase.
  task automatic apbRead(input logic [31:0] addr, output logic [15:0] data);
    @(negedge pclk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = addr;
    @(negedge pclk);
    penable = 1'b1;
    #1 data = prdata;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // Combinational read with no clock edge, usable while reset is held.
  task automatic peekReg(input logic [31:0] addr, output logic [15:0] data,
                         output logic err);
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = addr;
    #1 data = prdata;
    err     = pslverr;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // Capture pwm_o on the next 20 falling edges.
  task automatic sample20(output logic [31:0] vec);
    vec = 32'h0;
    repeat (20) begin
      @(negedge pclk);
      vec = {vec[30:0], pwm_o};
    end
  endtask

  // Stop the counter, load DUTY, then write CTRL (which restarts it) and capture.
  task automatic applyStimulus(input logic [15:0] dutyVal, input logic [15:0] ctrlVal,
                               output logic [31:0] vec);
    logic err;
    apbWrite(32'h8, 16'h0000, 2'b11, err);
    apbWrite(32'h0, dutyVal, 2'b11, err);
    apbWrite(32'h8, ctrlVal, 2'b11, err);
    sample20(vec);
  endtask

  initial begin
    logic [15:0] rd;
    logic        err;
    logic        errAcc;
    logic [31:0] vec;

    checkCount = 0;
    passCount  = 0;
    preset  = 1'b1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 16'h0;
    pstrb   = 2'b00;

    // Reset state, read while reset is still held
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checkOutput("reset_pwm", {31'h0, pwm_o}, 32'h0);
    checkOutput("reset_pready", {31'h0, pready}, 32'h1);
    peekReg(32'h0, rd, err);
    checkOutput("reset_duty", {16'h0, rd}, 32'h0000);
    checkOutput("reset_pslverr", {31'h0, err}, 32'h0);
    peekReg(32'h4, rd, err);
    checkOutput("reset_period", {16'h0, rd}, 32'hFFFF);
    peekReg(32'h8, rd, err);
    checkOutput("reset_ctrl", {16'h0, rd}, 32'h0001);
    peekReg(32'hC, rd, err);
    checkOutput("reset_cnt", {16'h0, rd}, 32'h0000);
    preset = 1'b0;

    // Basic PWM: PERIOD=9, DUTY=3 -> 3 high, 7 low
    apbWrite(32'h8, 16'h0000, 2'b11, err);
    apbWrite(32'h4, 16'd9, 2'b11, err);
    checkOutput("period_write_pslverr", {31'h0, err}, 32'h0);
    applyStimulus(16'd3, 16'h0001, vec);
    checkOutput("basic_pwm", vec, 32'h000E0380);

    // Double buffer: DUTY=7 committed at cnt=2, effective from the next period
    apbWrite(32'h0, 16'd7, 2'b11, err);
    sample20(vec);
    checkOutput("double_buffer", vec, 32'h00001FC7);

    // Limits and polarity
    applyStimulus(16'd0, 16'h0001, vec);
    checkOutput("duty_zero", vec, 32'h00000000);
    applyStimulus(16'd10, 16'h0001, vec);
    checkOutput("duty_full", vec, 32'h000FFFFF);
    applyStimulus(16'd3, 16'h0003, vec);
    checkOutput("polarity", vec, 32'h0001FC7F);

    // Counter stopped: CNT reads 0, output sits at POL
    apbWrite(32'h8, 16'h0002, 2'b11, err);
    repeat (2) @(negedge pclk);
    checkOutput("en_off_pwm", {31'h0, pwm_o}, 32'h1);
    apbRead(32'hC, rd);
    checkOutput("en_off_cnt", {16'h0, rd}, 32'h0000);
    apbRead(32'h8, rd);
    checkOutput("en_off_ctrl", {16'h0, rd}, 32'h0002);

    // Streaming writes: one DUTY write per clock
    errAcc = 1'b0;
    @(negedge pclk);
    psel   = 1'b1;
    pwrite = 1'b1;
    paddr  = 32'h0;
    pstrb  = 2'b11;
    pwdata = 16'h0100;
    @(negedge pclk);
    penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pwdata = 16'h0100 + 16'(i);
      #1 errAcc = errAcc | pslverr;
      @(negedge pclk);
    end
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    checkOutput("stream_pslverr", {31'h0, errAcc}, 32'h0);
    apbRead(32'h0, rd);
    checkOutput("stream_duty", {16'h0, rd}, 32'h0107);

    // Errors
    apbWrite(32'hC, 16'hABCD, 2'b11, err);
    checkOutput("cnt_write_pslverr", {31'h0, err}, 32'h1);
    apbRead(32'hC, rd);
    checkOutput("cnt_write_ignored", {16'h0, rd}, 32'h0000);
    apbWrite(32'h0, 16'h0042, 2'b11, err);
    apbWrite(32'h2, 16'h5555, 2'b11, err);
    checkOutput("misaligned_pslverr", {31'h0, err}, 32'h1);
    apbRead(32'h0, rd);
    checkOutput("misaligned_no_write", {16'h0, rd}, 32'h0042);

    // Byte strobes, plus upper-address aliasing
    apbWrite(32'h0, 16'hFFFF, 2'b11, err);
    apbWrite(32'h0, 16'h1234, 2'b01, err);
    apbRead(32'h0, rd);
    checkOutput("strobe_low", {16'h0, rd}, 32'hFF34);
    apbWrite(32'h0, 16'hAB00, 2'b10, err);
    apbRead(32'h1230, rd);
    checkOutput("strobe_high_alias", {16'h0, rd}, 32'hAB34);

    // Reset mid-run: output forced low on the following cycle
    checkOutput("pre_reset_pwm", {31'h0, pwm_o}, 32'h1);
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    checkOutput("mid_reset_pwm", {31'h0, pwm_o}, 32'h0);
    peekReg(32'h4, rd, err);
    checkOutput("mid_reset_period", {16'h0, rd}, 32'hFFFF);
    peekReg(32'h8, rd, err);
    checkOutput("mid_reset_ctrl", {16'h0, rd}, 32'h0001);
    preset = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
